// File: rtl/sd_arb_pkg.sv
// Shared types and defaults for the SD block-port arbiter and its round-robin picker.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER,
        RELEASE
    } arb_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } arb_op_t;

    localparam int GRANT_W = 3;

    // 0.25 s at 50 MHz before an unanswered strobe is abandoned.
    localparam logic [23:0] TO_CYC_DEFAULT = 24'd12_500_000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set bit of pend at or above rr_ptr, with wrap.
module rr_pick
    import sd_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]    pend,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic               found,
    output logic [GRANT_W-1:0] idx
);

    int rank;
    int best;

    // Rank is the distance from rr_ptr going upward; the lowest-ranked pending channel wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        best  = NREQ;
        rank  = 0;
        for (int i = 0; i < NREQ; i++) begin
            rank = (i + NREQ - int'(rr_ptr)) % NREQ;
            if (pend[i] && (rank < best)) begin
                best  = rank;
                found = 1'b1;
                idx   = GRANT_W'(i);
            end
        end
    end

endmodule

// File: rtl/sd_blk_arbiter.sv
// Shares one host SD block port among NREQ block requesters, one transfer at a time,
// with round-robin fairness and an ack timeout.
module sd_blk_arbiter
    import sd_arb_pkg::*;
#(
    parameter int              NREQ   = 4,
    parameter int              TO_W   = 24,
    parameter logic [TO_W-1:0] TO_CYC = TO_W'(TO_CYC_DEFAULT)
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [NREQ-1:0][31:0] req_lba,
    input  logic [NREQ-1:0]       req_rd,
    input  logic [NREQ-1:0]       req_wr,
    output logic [NREQ-1:0]       req_ack,
    input  logic [NREQ-1:0][7:0]  req_buff_din,
    output logic [NREQ-1:0]       req_buff_wr,
    output logic [31:0]           sd_lba,
    output logic                  sd_rd,
    output logic                  sd_wr,
    input  logic                  sd_ack,
    input  logic                  sd_buff_wr,
    output logic [7:0]            sd_buff_din,
    output logic [GRANT_W-1:0]    grant_id,
    output logic                  busy,
    output logic [NREQ-1:0]       timeout_flags
);

    localparam logic [TO_W-1:0]    TO_LAST = TO_CYC - 1'b1;
    localparam logic [GRANT_W-1:0] LAST_CH = GRANT_W'(NREQ - 1);

    arb_state_t         state;
    arb_op_t            op;
    logic [TO_W-1:0]    timer;
    logic [GRANT_W-1:0] rr_ptr;

    logic [NREQ-1:0]    pend;
    logic               found;
    logic [GRANT_W-1:0] pick_idx;
    logic [31:0]        pick_lba;
    logic               pick_wr;
    logic [NREQ-1:0]    grant_onehot;

    assign pend = req_rd | req_wr;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .pend   (pend),
        .rr_ptr (rr_ptr),
        .found  (found),
        .idx    (pick_idx)
    );

    always_comb begin
        pick_lba     = '0;
        pick_wr      = 1'b0;
        grant_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == GRANT_W'(i)) begin
                pick_lba = req_lba[i];
                pick_wr  = req_wr[i];
            end
            grant_onehot[i] = (grant_id == GRANT_W'(i));
        end
    end

    // Only the granted channel sees host ack and byte strobes, and only during the data phase.
    always_comb begin
        req_ack     = '0;
        req_buff_wr = '0;
        sd_buff_din = 8'h00;
        if (state == XFER) begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant_onehot[i]) begin
                    req_ack[i]     = sd_ack;
                    req_buff_wr[i] = sd_buff_wr;
                    sd_buff_din    = req_buff_din[i];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            op            <= OP_RD;
            timer         <= '0;
            rr_ptr        <= '0;
            grant_id      <= '0;
            sd_lba        <= '0;
            sd_rd         <= 1'b0;
            sd_wr         <= 1'b0;
            busy          <= 1'b0;
            timeout_flags <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= pick_idx;
                        sd_lba   <= pick_lba;
                        op       <= pick_wr ? OP_WR : OP_RD;
                        busy     <= 1'b1;
                        timer    <= '0;
                        state    <= ISSUE;
                    end
                end
                // The host owns the transfer once strobed; a requester dropping its level is ignored.
                ISSUE: begin
                    if (sd_ack) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= XFER;
                    end else if (timer == TO_LAST) begin
                        sd_rd         <= 1'b0;
                        sd_wr         <= 1'b0;
                        timeout_flags <= timeout_flags | grant_onehot;
                        state         <= RELEASE;
                    end else begin
                        sd_rd <= (op == OP_RD);
                        sd_wr <= (op == OP_WR);
                        if (timer != {TO_W{1'b1}}) begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (!sd_ack) begin
                        timeout_flags <= timeout_flags & ~grant_onehot;
                        state         <= RELEASE;
                    end
                end
                RELEASE: begin
                    rr_ptr <= (grant_id == LAST_CH) ? '0 : grant_id + 1'b1;
                    busy   <= 1'b0;
                    timer  <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_blk_arbiter.sv
// Scoreboard bench: each expected host strobe is queued, a monitor checks grant/lba/op on every strobe rise.
module tb_sd_blk_arbiter;

    typedef struct packed {
        logic [2:0]  grant;
        logic [31:0] lba;
        logic        wr;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0][31:0] req_lba;
    logic [3:0]       req_rd;
    logic [3:0]       req_wr;
    logic [3:0]       req_ack;
    logic [3:0][7:0]  req_buff_din;
    logic [3:0]       req_buff_wr;
    logic [31:0]      sd_lba;
    logic             sd_rd;
    logic             sd_wr;
    logic             sd_ack;
    logic             sd_buff_wr;
    logic [7:0]       sd_buff_din;
    logic [2:0]       grant_id;
    logic             busy;
    logic [3:0]       timeout_flags;

    int   check_count = 0;
    int   pass_count  = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_strobe = 1'b0;

    sd_blk_arbiter #(
        .NREQ   (4),
        .TO_W   (24),
        .TO_CYC (24'd16)
    ) dut (
        .CLK           (clk),
        .RESET_N       (rst_n),
        .req_lba       (req_lba),
        .req_rd        (req_rd),
        .req_wr        (req_wr),
        .req_ack       (req_ack),
        .req_buff_din  (req_buff_din),
        .req_buff_wr   (req_buff_wr),
        .sd_lba        (sd_lba),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .sd_ack        (sd_ack),
        .sd_buff_wr    (sd_buff_wr),
        .sd_buff_din   (sd_buff_din),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_flags (timeout_flags)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [3:0] rd, input logic [3:0] wr);
        req_rd = rd;
        req_wr = wr;
    endtask

    task automatic expectGrant(input int ch, input logic [31:0] lba, input logic wr);
        exp_t e;
        e.grant = 3'(ch);
        e.lba   = lba;
        e.wr    = wr;
        exp_q.push_back(e);
    endtask

    task automatic wait_strobe(output bit ok);
        int waited;
        waited = 0;
        while (!(sd_rd || sd_wr) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        ok = sd_rd || sd_wr;
        if (!ok) checkOutput("strobe_wait", 32'(sd_rd | sd_wr), 32'd1);
    endtask

    // Host model: ack the strobe, clock nbytes through, drop ack; requester levels are updated
    // when the ack reaches them and again in the release cycle.
    task automatic serve_one(input int ch, input int nbytes, input logic [7:0] exp_din,
                             input logic [3:0] ack_rd, input logic [3:0] ack_wr,
                             input logic [3:0] end_rd, input logic [3:0] end_wr);
        bit ok;
        wait_strobe(ok);
        if (!ok) return;
        sd_ack = 1'b1;
        @(negedge clk);
        checkOutput("strobe_drop_on_ack", 32'({sd_rd, sd_wr}), 32'd0);
        checkOutput("ack_route", 32'(req_ack), 32'(1 << ch));
        applyStimulus(ack_rd, ack_wr);
        for (int b = 0; b < nbytes; b++) begin
            sd_buff_wr = 1'b1;
            #1;
            if (b == 0 || b == nbytes - 1) begin
                checkOutput("buff_wr_route", 32'(req_buff_wr), 32'(1 << ch));
                checkOutput("buff_din_route", 32'(sd_buff_din), 32'(exp_din));
            end
            @(negedge clk);
            sd_buff_wr = 1'b0;
            @(negedge clk);
        end
        sd_ack = 1'b0;
        @(negedge clk);
        checkOutput("busy_in_release", 32'(busy), 32'd1);
        checkOutput("ack_off_in_release", 32'(req_ack), 32'd0);
        applyStimulus(end_rd, end_wr);
        @(negedge clk);
        checkOutput("busy_after_release", 32'(busy), 32'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if ((sd_rd || sd_wr) && !prev_strobe) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_strobe", 32'({sd_wr, sd_rd}), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("grant_id", 32'(grant_id), 32'(mon_e.grant));
                    checkOutput("sd_lba", sd_lba, mon_e.lba);
                    checkOutput("sd_op", 32'({sd_wr, sd_rd}), mon_e.wr ? 32'd2 : 32'd1);
                end
            end
            prev_strobe = sd_rd || sd_wr;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] keep;
        int         cycles;
        bit         seen_rd;
        bit         ok;
        logic [3:0] ack_seen;
        logic       activity;

        rst_n        = 1'b0;
        req_lba      = '0;
        req_buff_din = '0;
        sd_ack       = 1'b0;
        sd_buff_wr   = 1'b0;
        applyStimulus(4'h0, 4'h0);
        repeat (3) @(negedge clk);
        checkOutput("rst_sd_rd", 32'(sd_rd), 32'd0);
        checkOutput("rst_sd_wr", 32'(sd_wr), 32'd0);
        checkOutput("rst_sd_lba", sd_lba, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
        checkOutput("rst_timeout_flags", 32'(timeout_flags), 32'd0);
        checkOutput("rst_req_ack", 32'(req_ack), 32'd0);
        checkOutput("rst_sd_buff_din", 32'(sd_buff_din), 32'd0);
        rst_n = 1'b1;

        // Host ack and byte strobes with nothing granted must be ignored.
        sd_ack     = 1'b1;
        sd_buff_wr = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_ack_busy", 32'(busy), 32'd0);
        checkOutput("idle_ack_route", 32'(req_ack), 32'd0);
        checkOutput("idle_buff_wr_route", 32'(req_buff_wr), 32'd0);
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        @(negedge clk);

        $display("[TB] fairness: all four channels re-requesting");
        for (int i = 0; i < 4; i++) req_lba[i] = 32'h100 + 32'(i);
        expectGrant(0, 32'h100, 1'b0);
        expectGrant(1, 32'h101, 1'b0);
        expectGrant(2, 32'h102, 1'b0);
        expectGrant(3, 32'h103, 1'b0);
        expectGrant(0, 32'h100, 1'b0);
        applyStimulus(4'hF, 4'h0);
        for (int t = 0; t < 5; t++) begin
            keep = 4'hF & ~4'(1 << (t % 4));
            serve_one(t % 4, 2, 8'h00, (t < 4) ? keep : 4'h0, 4'h0,
                      (t < 4) ? 4'hF : 4'h0, 4'h0);
        end

        $display("[TB] single read on channel 2");
        req_lba[2] = 32'h12;
        expectGrant(2, 32'h12, 1'b0);
        applyStimulus(4'b0100, 4'h0);
        @(negedge clk);
        checkOutput("arb_busy", 32'(busy), 32'd1);
        checkOutput("arb_grant_id", 32'(grant_id), 32'd2);
        checkOutput("arb_sd_rd_not_yet", 32'(sd_rd), 32'd0);
        @(negedge clk);
        checkOutput("issue_sd_rd", 32'(sd_rd), 32'd1);
        checkOutput("issue_sd_lba", sd_lba, 32'h12);
        serve_one(2, 256, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0);

        $display("[TB] write routing on channel 1");
        req_lba[1]      = 32'h2000;
        req_buff_din[1] = 8'hA5;
        expectGrant(1, 32'h2000, 1'b1);
        applyStimulus(4'h0, 4'b0010);
        serve_one(1, 4, 8'hA5, 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("buff_din_after_release", 32'(sd_buff_din), 32'd0);
        req_buff_din[1] = 8'h00;

        $display("[TB] read and write both set on channel 3");
        req_lba[3] = 32'h3333;
        expectGrant(3, 32'h3333, 1'b1);
        expectGrant(3, 32'h3333, 1'b0);
        applyStimulus(4'b1000, 4'b1000);
        serve_one(3, 2, 8'h00, 4'b1000, 4'h0, 4'b1000, 4'h0);
        serve_one(3, 2, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0);

        $display("[TB] ack timeout on channel 0");
        req_lba[0] = 32'h40;
        req_lba[1] = 32'h41;
        expectGrant(0, 32'h40, 1'b0);
        expectGrant(1, 32'h41, 1'b0);
        expectGrant(0, 32'h40, 1'b0);
        applyStimulus(4'b0011, 4'h0);
        @(negedge clk);
        checkOutput("to_busy", 32'(busy), 32'd1);
        cycles   = 0;
        seen_rd  = 1'b0;
        ack_seen = 4'h0;
        while (cycles < 40) begin
            @(negedge clk);
            cycles++;
            ack_seen |= req_ack;
            if (seen_rd && !sd_rd) break;
            seen_rd |= sd_rd;
        end
        checkOutput("to_strobe_cycles", 32'(cycles), 32'd16);
        checkOutput("to_flag_set", 32'(timeout_flags), 32'b0001);
        checkOutput("to_no_ack", 32'(ack_seen), 32'd0);
        serve_one(1, 2, 8'h00, 4'b0001, 4'h0, 4'b0001, 4'h0);
        checkOutput("to_flag_held", 32'(timeout_flags), 32'b0001);
        serve_one(0, 2, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("to_flag_cleared", 32'(timeout_flags), 32'd0);

        $display("[TB] reset in the middle of a transfer");
        req_lba[2] = 32'h77;
        expectGrant(2, 32'h77, 1'b0);
        applyStimulus(4'b0100, 4'h0);
        wait_strobe(ok);
        sd_ack = 1'b1;
        @(negedge clk);
        checkOutput("pre_reset_ack", 32'(req_ack), 32'b0100);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_sd_rd", 32'(sd_rd), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_req_ack", 32'(req_ack), 32'd0);
        checkOutput("async_rst_sd_lba", sd_lba, 32'd0);
        applyStimulus(4'h0, 4'h0);
        sd_ack = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        activity = 1'b0;
        repeat (10) begin
            @(negedge clk);
            activity |= sd_rd | sd_wr | busy;
        end
        checkOutput("post_reset_quiet", 32'(activity), 32'd0);

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
